// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - two-requester sram-like arbiter onto one shared memory port
//
// Ports:
//   clk, reset                 single clock, synchronous active-high reset
//   inst_* (req/wr/size/wstrb/addr/wdata in; addr_ok/data_ok/rdata out)
//   data_* (same as inst_*, higher priority requester)
//   mem_*  (req/wr/size/wstrb/addr/wdata out; addr_ok/data_ok/rdata in)
//
// Grants go to the data side first. A grant is held until the shared
// port accepts, so a requester that is waiting keeps the port even if the
// other side raises req meanwhile. Accepted transactions are tagged with
// their source in an in-order FIFO; mem_data_ok is steered to whichever
// side sits at the FIFO head.
module mem_req_arbiter #(
    parameter int OT_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int PW = (OT_DEPTH > 1) ? $clog2(OT_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(OT_DEPTH);

    // Source tag stored per outstanding transaction.
    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HOLD_INST = 2'd1,
        HOLD_DATA = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_INST = 2'd1,
        GNT_DATA = 2'd2
    } grant_t;

    state_t  state, state_next;
    grant_t  grant;

    logic [OT_DEPTH-1:0] tag_mem;
    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       wr_ptr;
    logic [CW-1:0]       count;

    logic push;
    logic pop;
    logic head_tag;

    // Grant selection and next state. The full check uses the registered
    // count, so a pop in the full cycle only frees a grant one cycle later.
    always_comb begin
        grant      = GNT_NONE;
        state_next = state;
        case (state)
            IDLE: begin
                if (count < FULL_COUNT) begin
                    if (data_req) begin
                        grant = GNT_DATA;
                    end else if (inst_req) begin
                        grant = GNT_INST;
                    end
                end
                if (!mem_addr_ok) begin
                    if (grant == GNT_DATA) begin
                        state_next = HOLD_DATA;
                    end else if (grant == GNT_INST) begin
                        state_next = HOLD_INST;
                    end
                end
            end
            HOLD_INST: begin
                grant = GNT_INST;
                if (mem_addr_ok) begin
                    state_next = IDLE;
                end
            end
            HOLD_DATA: begin
                grant = GNT_DATA;
                if (mem_addr_ok) begin
                    state_next = IDLE;
                end
            end
            default: begin
                grant      = GNT_NONE;
                state_next = IDLE;
            end
        endcase
    end

    // Shared-port mux; payload defaults to the data side when nothing is granted.
    always_comb begin
        mem_req   = 1'b0;
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_wstrb = data_wstrb;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
        if (grant == GNT_INST) begin
            mem_req   = inst_req;
            mem_wr    = inst_wr;
            mem_size  = inst_size;
            mem_wstrb = inst_wstrb;
            mem_addr  = inst_addr;
            mem_wdata = inst_wdata;
        end else if (grant == GNT_DATA) begin
            mem_req   = data_req;
        end
    end

    assign push     = mem_req & mem_addr_ok;
    assign pop      = mem_data_ok & (count != '0);
    assign head_tag = tag_mem[rd_ptr];

    assign inst_addr_ok = mem_addr_ok & mem_req & (grant == GNT_INST);
    assign data_addr_ok = mem_addr_ok & mem_req & (grant == GNT_DATA);

    assign inst_data_ok = pop & (head_tag == SRC_INST);
    assign data_data_ok = pop & (head_tag == SRC_DATA);

    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Pointers wrap naturally because OT_DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Tag storage carries no reset: entries are only read once counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr] <= (grant == GNT_DATA) ? SRC_DATA : SRC_INST;
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb/tb_mem_req_arbiter.sv - scoreboard bench for mem_req_arbiter
module tb_mem_req_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    mem_req_arbiter #(.OT_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_wstrb(mem_wstrb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    localparam int IADDR = 0;
    localparam int DADDR = 1;
    localparam int IDATA = 2;
    localparam int DDATA = 3;

    typedef struct {
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    bit   done    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    task automatic expect_evt(input int kind, input logic [31:0] v);
        exp_t e;
        e.kind = kind;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic sb_chk(input int kind, input logic [31:0] v);
        exp_t e;
        n_total++;
        if (sb.size() == 0) begin
            $display("FAIL unexpected_event: got kind %0d value %h expected no event", kind, v);
        end else begin
            e = sb.pop_front();
            if (e.kind == kind && e.val === v) n_pass++;
            else $display("FAIL scoreboard: got kind %0d value %h expected kind %0d value %h",
                          kind, v, e.kind, e.val);
        end
    endtask

    // Monitor: within a cycle, accept events come before response events.
    initial begin
        forever begin
            @(negedge clk);
            if (!done && !reset) begin
                if (data_addr_ok) sb_chk(DADDR, mem_addr);
                if (inst_addr_ok) sb_chk(IADDR, mem_addr);
                if (data_data_ok) sb_chk(DDATA, data_rdata);
                if (inst_data_ok) sb_chk(IDATA, inst_rdata);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic setin(input logic ir, input logic dr, input logic aok,
                         input logic dok, input logic [31:0] rd);
        inst_req    = ir;
        data_req    = dr;
        mem_addr_ok = aok;
        mem_data_ok = dok;
        mem_rdata   = rd;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // One cycle: drive, optionally expect one event, step.
    task automatic cyc(input logic ir, input logic dr, input logic aok, input logic dok,
                       input logic [31:0] rd, input int kind, input logic [31:0] v);
        setin(ir, dr, aok, dok, rd);
        if (kind >= 0) expect_evt(kind, v);
        @(negedge clk);
        adv();
    endtask

    task automatic acc_i(); cyc(1, 0, 1, 0, 0, IADDR, inst_addr); endtask
    task automatic acc_d(); cyc(0, 1, 1, 0, 0, DADDR, data_addr); endtask
    task automatic rsp_i(input logic [31:0] v); cyc(0, 0, 0, 1, v, IDATA, v); endtask
    task automatic rsp_d(input logic [31:0] v); cyc(0, 0, 0, 1, v, DDATA, v); endtask

    initial begin
        reset = 1'b1;
        inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'h0;
        inst_addr = 32'h1000_0000; inst_wdata = 32'h0;
        data_wr = 0; data_size = 2'd2; data_wstrb = 4'h0;
        data_addr = 32'h2000_0000; data_wdata = 32'h0;
        setin(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state outputs
        @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_inst_addr_ok", inst_addr_ok, 0);
        chk("rst_data_addr_ok", data_addr_ok, 0);
        chk("rst_inst_data_ok", inst_data_ok, 0);
        chk("rst_data_data_ok", data_data_ok, 0);
        adv();

        // Both request together: data first (a write), then inst
        inst_addr = 32'h1000_0010; data_addr = 32'h2000_0010;
        data_wr = 1; data_wstrb = 4'hc; data_wdata = 32'hdead_beef;
        setin(1, 1, 1, 0, 0);
        expect_evt(DADDR, data_addr);
        @(negedge clk);
        chk("A0_mem_addr", mem_addr, 32'h2000_0010);
        chk("A0_mem_wr", mem_wr, 1);
        chk("A0_mem_wstrb", mem_wstrb, 4'hc);
        chk("A0_mem_wdata", mem_wdata, 32'hdead_beef);
        chk("A0_inst_addr_ok", inst_addr_ok, 0);
        adv();
        data_wr = 0; data_wstrb = 4'h0;
        setin(1, 0, 1, 0, 0);
        expect_evt(IADDR, inst_addr);
        @(negedge clk);
        chk("A1_mem_addr", mem_addr, 32'h1000_0010);
        adv();
        rsp_d(32'h0000_00a1);
        rsp_i(32'h0000_00a2);

        // Held inst grant while data waits
        inst_addr = 32'h1000_0020; data_addr = 32'h2000_0020;
        for (int c = 0; c < 4; c++) begin
            setin(1, (c != 0), 0, 0, 0);
            @(negedge clk);
            chk($sformatf("B%0d_mem_addr", c), mem_addr, 32'h1000_0020);
            chk($sformatf("B%0d_mem_req", c), mem_req, 1);
            adv();
        end
        setin(1, 1, 1, 0, 0);
        expect_evt(IADDR, inst_addr);
        @(negedge clk);
        chk("B4_mem_addr", mem_addr, 32'h1000_0020);
        adv();
        cyc(0, 1, 1, 0, 0, DADDR, 32'h2000_0020);
        rsp_i(32'h0000_00b1);
        rsp_d(32'h0000_00b2);

        // Full FIFO blocks grants; a pop frees the grant one cycle later
        inst_addr = 32'h1000_0030; data_addr = 32'h2000_0030;
        acc_i(); acc_d(); acc_i(); acc_d();
        setin(1, 0, 1, 0, 0);
        @(negedge clk);
        chk("C_full_mem_req", mem_req, 0);
        adv();
        setin(1, 0, 1, 1, 32'h0000_0055);
        expect_evt(IDATA, 32'h0000_0055);
        @(negedge clk);
        chk("C_pop_mem_req", mem_req, 0);
        adv();
        setin(1, 0, 1, 0, 0);
        expect_evt(IADDR, inst_addr);
        @(negedge clk);
        chk("C_after_mem_req", mem_req, 1);
        adv();
        rsp_d(32'h0000_00c1); rsp_i(32'h0000_00c2);
        rsp_d(32'h0000_00c3); rsp_i(32'h0000_00c4);

        // In-order response steering, then a stray data_ok on empty FIFO
        acc_i(); acc_d(); acc_i();
        rsp_i(32'h0000_0011);
        rsp_d(32'h0000_0022);
        rsp_i(32'h0000_0033);
        cyc(0, 0, 0, 1, 32'h0000_0044, -1, 0);

        // Push and pop in the same cycle, pointers wrap
        acc_d(); acc_i();
        setin(1, 0, 1, 1, 32'h0000_0077);
        expect_evt(IADDR, inst_addr); expect_evt(DDATA, 32'h0000_0077);
        @(negedge clk); adv();
        setin(0, 1, 1, 1, 32'h0000_0078);
        expect_evt(DADDR, data_addr); expect_evt(IDATA, 32'h0000_0078);
        @(negedge clk); adv();
        setin(0, 1, 1, 1, 32'h0000_0079);
        expect_evt(DADDR, data_addr); expect_evt(IDATA, 32'h0000_0079);
        @(negedge clk); adv();
        setin(1, 0, 1, 1, 32'h0000_007a);
        expect_evt(IADDR, inst_addr); expect_evt(DDATA, 32'h0000_007a);
        @(negedge clk); adv();
        rsp_d(32'h0000_007b);
        rsp_i(32'h0000_007c);
        cyc(0, 0, 0, 1, 32'h0000_007d, -1, 0);

        // Reset drops outstanding transactions
        acc_i(); acc_d();
        setin(0, 0, 0, 0, 0);
        reset = 1'b1;
        adv();
        reset = 1'b0;
        setin(0, 0, 0, 1, 32'h0000_0099);
        @(negedge clk);
        chk("F_inst_data_ok", inst_data_ok, 0);
        chk("F_data_data_ok", data_data_ok, 0);
        chk("F_mem_req", mem_req, 0);
        adv();
        acc_i();
        rsp_i(32'h0000_00f1);
        cyc(0, 0, 0, 1, 32'h0000_00f2, -1, 0);

        setin(0, 0, 0, 0, 0);
        adv();
        done = 1'b1;
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
